mem_req_arbiter: RTL and testbench
==================================

# mem_req_arbiter

Shares the single memory-side request channel of the AXI adapter between the instruction cache (port 0) and the write-through data cache (port 1). It grants one request at a time and tags each forwarded request with a source bit prepended to the cache TID. It caps outstanding transactions per requester and routes responses back by ID. A drain handshake blocks new grants until all in-flight traffic has completed, for fences and cache flushes.

## Interface
- NUM_REQ, 2, number of requesters; fixed at 2 (0 = icache, 1 = dcache)
- ADDR_WIDTH, 64, request address width
- DATA_WIDTH, 64, request/response data width
- TID_WIDTH, 2, cache transaction ID width; downstream ID is TID_WIDTH+1 ≤ AXI ID width (4)
- MAX_OUTSTANDING, 4, per-requester cap on accepted but unanswered requests
- clk_i  in  1  clock
- rst_i  in  1  reset; asynchronous, active-high
- req_valid_i  in  NUM_REQ  per-requester request valid
- req_ready_o  out  NUM_REQ  per-requester accept
- req_addr_i  in  NUM_REQ×ADDR_WIDTH  request address
- req_we_i  in  NUM_REQ  1 = write
- req_wdata_i  in  NUM_REQ×DATA_WIDTH  write data
- req_be_i  in  NUM_REQ×DATA_WIDTH/8  byte enables
- req_tid_i  in  NUM_REQ×TID_WIDTH  cache TID
- mem_req_valid_o  out  1  downstream request valid (registered)
- mem_req_ready_i  in  1  downstream accept
- mem_req_addr_o / mem_req_we_o / mem_req_wdata_o / mem_req_be_o  out  as above  registered payload
- mem_req_id_o  out  TID_WIDTH+1  {source, tid}
- mem_rsp_valid_i  in  1  response valid; there is no backpressure
- mem_rsp_id_i  in  TID_WIDTH+1  response ID
- mem_rsp_data_i  in  DATA_WIDTH  response data
- rsp_valid_o  out  NUM_REQ  one-hot response strobe
- rsp_tid_o  out  TID_WIDTH  response TID, broadcast to both requesters
- rsp_data_o  out  DATA_WIDTH  response data, broadcast to both requesters
- drain_req_i  in  1  request a quiesce
- drain_done_o  out  1  quiesced
- err_o  out  1  sticky: response for a requester with zero outstanding

## Operation
- FSM states: ARB, HOLD, DRAIN. The reset state is ARB.
- ARB:
  - If drain_req_i is high, go to DRAIN. Drain has priority over new grants.
  - Otherwise pick a winner among eligible requesters. A requester is eligible when valid is high and its outstanding count is below MAX_OUTSTANDING.
  - Assert req_ready_o[winner] combinationally and latch the payload, with id {winner, tid}, into the output register. Go to HOLD.
- HOLD:
  - mem_req_valid_o = 1. The payload is held stable until mem_req_ready_i is high.
  - On the handshake, go to ARB, or to DRAIN if drain_req_i is high.
  - req_ready_o = 0 in this state.
- DRAIN:
  - No grants.
  - drain_done_o = 1 while both counters are zero and the output register is empty.
  - When drain_req_i deasserts, go to ARB.
- Arbitration is round-robin over a last-grant pointer:
  - The requester that was not granted last wins if it is eligible; otherwise the other requester wins.
  - The pointer updates only on a grant.
- Outstanding counters: one per requester, width $clog2(MAX_OUTSTANDING+1).
  - Increment on an upstream accept.
  - Decrement on mem_rsp_valid_i with mem_rsp_id_i[TID_WIDTH] equal to that requester.
  - A simultaneous accept and response for the same requester leaves the count unchanged.
- Response routing: rsp_valid_o[mem_rsp_id_i[TID_WIDTH]] = mem_rsp_valid_i, combinational. rsp_tid_o and rsp_data_o pass through.
- A response aimed at a counter that is zero sets err_o. The counter is not decremented.
- Reset values: mem_req_valid_o = 0; payload/ID registers = 0; counters = 0; pointer = 1, so the icache wins the first tie; err_o = 0. drain_done_o is 0 while in ARB and HOLD.
- Reset asserted mid-HOLD drops mem_req_valid_o asynchronously and discards the pending request.

## Timing
- Upstream accept in cycle N → mem_req_valid_o high from N+1.
- Peak throughput is one request every 2 cycles, because HOLD always returns through ARB.
- Response path has 0-cycle latency, with no registers.
- drain_done_o is registered-state derived. It rises one cycle after the last counter reaches zero in DRAIN.

## Configuration
- MEM_REQ_ARB_DCACHE_PRIO_EN defined: fixed priority, so the dcache (port 1) always wins when eligible. The pointer is unused.
- MEM_REQ_ARB_DCACHE_PRIO_EN undefined: round-robin as described above.

## Structure
- The shared package holds:
  - the state enum (ARB/HOLD/DRAIN)
  - localparams REQ_ICACHE = 0 and REQ_DCACHE = 1
  - a packed request struct {addr, we, wdata, be, tid}
  - a function building the downstream ID
- One sub-module, mem_req_rr_pick: 2-input round-robin/fixed-priority picker with a pointer register. It takes eligible[1:0] and outputs a one-hot grant.

## Test plan
- Both requesters valid continuously, round-robin build → grants alternate 0,1,0,1 starting with 0. IDs are 0b0tt and 0b1tt.
- mem_req_ready_i held low for 5 cycles in HOLD → payload and ID stable and req_ready_o = 0 throughout. Release → next grant 2 cycles later.
- dcache issues 4 writes with no responses (MAX_OUTSTANDING = 4) → the 5th stays unaccepted while the icache is still granted. One response with ID 0b100 → dcache accepted again.
- Same-cycle dcache accept and dcache response → counter unchanged. Response ID 0b001 with the icache count at 0 → err_o = 1 and sticky.
- drain_req_i raised with 2 icache requests outstanding → no grants. drain_done_o rises one cycle after the second response and falls when drain_req_i drops.
- rst_i pulsed during HOLD → mem_req_valid_o = 0 immediately; counters and err_o cleared; first post-reset tie goes to the icache.

Source files
------------

// File: rtl/mem_req_arbiter_pkg.sv
// Shared types and constants for the memory request arbiter.
// Build option: MEM_REQ_ARB_DCACHE_PRIO_EN selects fixed dcache priority in mem_req_rr_pick.
package mem_req_arbiter_pkg;

  localparam int unsigned NUM_REQ         = 2;
  localparam int unsigned ADDR_WIDTH      = 64;
  localparam int unsigned DATA_WIDTH      = 64;
  localparam int unsigned BE_WIDTH        = DATA_WIDTH / 8;
  localparam int unsigned TID_WIDTH       = 2;
  localparam int unsigned ID_WIDTH        = TID_WIDTH + 1;
  localparam int unsigned MAX_OUTSTANDING = 4;
  localparam int unsigned CNT_WIDTH       = $clog2(MAX_OUTSTANDING + 1);

  localparam int unsigned REQ_ICACHE = 0;
  localparam int unsigned REQ_DCACHE = 1;

  typedef enum logic [1:0] {
    ST_ARB,
    ST_HOLD,
    ST_DRAIN
  } state_e;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic                  we;
    logic [DATA_WIDTH-1:0] wdata;
    logic [BE_WIDTH-1:0]   be;
    logic [TID_WIDTH-1:0]  tid;
  } mem_req_t;

  // Downstream ID: source requester bit on top of the cache TID.
  function automatic logic [ID_WIDTH-1:0] build_id(input logic src,
                                                   input logic [TID_WIDTH-1:0] tid);
    return {src, tid};
  endfunction

endpackage

// File: rtl/mem_req_rr_pick.sv
// Two-input grant picker: round-robin over a last-grant pointer by default,
// fixed dcache priority when MEM_REQ_ARB_DCACHE_PRIO_EN is defined.
module mem_req_rr_pick
  import mem_req_arbiter_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] eligible_i,
  input  logic       update_i,
  output logic [1:0] grant_c
);

`ifdef MEM_REQ_ARB_DCACHE_PRIO_EN
  logic unused_pick;
  assign unused_pick = ^{clk_i, rst_i, update_i};

  // Dcache wins whenever it is eligible.
  always_comb begin
    grant_c = '0;
    if (eligible_i[REQ_DCACHE]) begin
      grant_c[REQ_DCACHE] = 1'b1;
    end else if (eligible_i[REQ_ICACHE]) begin
      grant_c[REQ_ICACHE] = 1'b1;
    end
  end
`else
  logic last_q;
  logic last_d;

  // Prefer the requester not granted last; fall back to the other one.
  always_comb begin
    grant_c = '0;
    last_d  = last_q;
    if (eligible_i[~last_q]) begin
      grant_c[~last_q] = 1'b1;
    end else if (eligible_i[last_q]) begin
      grant_c[last_q] = 1'b1;
    end
    if (update_i && (|grant_c)) begin
      last_d = grant_c[1];
    end
  end

  // Pointer resets to the dcache so the icache wins the first tie.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end
`endif

endmodule

// File: rtl/mem_req_arbiter.sv
// Arbitrates icache/dcache requests onto one memory channel, tracks
// per-requester outstanding counts, routes responses by ID, supports drain.
// Build option: MEM_REQ_ARB_DCACHE_PRIO_EN (fixed dcache priority).
module mem_req_arbiter
  import mem_req_arbiter_pkg::*;
(
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic [NUM_REQ-1:0]                   req_valid_i,
  output logic [NUM_REQ-1:0]                   req_ready_o,
  input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]   req_addr_i,
  input  logic [NUM_REQ-1:0]                   req_we_i,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]   req_wdata_i,
  input  logic [NUM_REQ-1:0][BE_WIDTH-1:0]     req_be_i,
  input  logic [NUM_REQ-1:0][TID_WIDTH-1:0]    req_tid_i,
  output logic                                 mem_req_valid_o,
  input  logic                                 mem_req_ready_i,
  output logic [ADDR_WIDTH-1:0]                mem_req_addr_o,
  output logic                                 mem_req_we_o,
  output logic [DATA_WIDTH-1:0]                mem_req_wdata_o,
  output logic [BE_WIDTH-1:0]                  mem_req_be_o,
  output logic [ID_WIDTH-1:0]                  mem_req_id_o,
  input  logic                                 mem_rsp_valid_i,
  input  logic [ID_WIDTH-1:0]                  mem_rsp_id_i,
  input  logic [DATA_WIDTH-1:0]                mem_rsp_data_i,
  output logic [NUM_REQ-1:0]                   rsp_valid_o,
  output logic [TID_WIDTH-1:0]                 rsp_tid_o,
  output logic [DATA_WIDTH-1:0]                rsp_data_o,
  input  logic                                 drain_req_i,
  output logic                                 drain_done_o,
  output logic                                 err_o
);

  state_e                             state_q, state_d;
  logic                               valid_q, valid_d;
  mem_req_t                           pay_q, pay_d;
  logic [ID_WIDTH-1:0]                id_q, id_d;
  logic [NUM_REQ-1:0][CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                               err_q, err_d;

  logic [NUM_REQ-1:0] eligible_c;
  logic [1:0]         grant_c;
  logic               pick_en_c;
  logic               win_c;
  logic               rsp_src_c;

  assign rsp_src_c = mem_rsp_id_i[TID_WIDTH];
  assign pick_en_c = (state_q == ST_ARB) && !drain_req_i;
  assign win_c     = grant_c[1];

  // Eligible: requesting and below the outstanding cap.
  always_comb begin
    eligible_c = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      eligible_c[i] = req_valid_i[i] && (cnt_q[i] < CNT_WIDTH'(MAX_OUTSTANDING));
    end
  end

  mem_req_rr_pick u_pick (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .eligible_i (eligible_c),
    .update_i   (pick_en_c),
    .grant_c    (grant_c)
  );

  // Next-state, upstream accept and output-register load.
  always_comb begin
    state_d     = state_q;
    valid_d     = valid_q;
    pay_d       = pay_q;
    id_d        = id_q;
    req_ready_o = '0;
    case (state_q)
      ST_ARB: begin
        if (drain_req_i) begin
          state_d = ST_DRAIN;
        end else if (|grant_c) begin
          req_ready_o = grant_c;
          valid_d     = 1'b1;
          pay_d.addr  = req_addr_i[win_c];
          pay_d.we    = req_we_i[win_c];
          pay_d.wdata = req_wdata_i[win_c];
          pay_d.be    = req_be_i[win_c];
          pay_d.tid   = req_tid_i[win_c];
          id_d        = build_id(win_c, req_tid_i[win_c]);
          state_d     = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (mem_req_ready_i) begin
          valid_d = 1'b0;
          state_d = drain_req_i ? ST_DRAIN : ST_ARB;
        end
      end
      ST_DRAIN: begin
        if (!drain_req_i) begin
          state_d = ST_ARB;
        end
      end
      default: state_d = ST_ARB;
    endcase
  end

  // Outstanding counters; a response to an idle requester flags an error.
  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      logic acc;
      logic dec;
      acc = req_ready_o[i];
      dec = mem_rsp_valid_i && (rsp_src_c == 1'(i));
      if (dec && (cnt_q[i] == '0)) begin
        err_d = 1'b1;
        dec   = 1'b0;
      end
      if (acc && !dec) begin
        cnt_d[i] = cnt_q[i] + CNT_WIDTH'(1);
      end else if (!acc && dec) begin
        cnt_d[i] = cnt_q[i] - CNT_WIDTH'(1);
      end
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_ARB;
      valid_q <= 1'b0;
      pay_q   <= '0;
      id_q    <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      pay_q   <= pay_d;
      id_q    <= id_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Zero-latency response routing by source bit.
  always_comb begin
    rsp_valid_o = '0;
    if (mem_rsp_valid_i) begin
      rsp_valid_o[rsp_src_c] = 1'b1;
    end
  end

  assign rsp_tid_o       = mem_rsp_id_i[TID_WIDTH-1:0];
  assign rsp_data_o      = mem_rsp_data_i;
  assign mem_req_valid_o = valid_q;
  assign mem_req_addr_o  = pay_q.addr;
  assign mem_req_we_o    = pay_q.we;
  assign mem_req_wdata_o = pay_q.wdata;
  assign mem_req_be_o    = pay_q.be;
  assign mem_req_id_o    = id_q;
  assign err_o           = err_q;
  assign drain_done_o    = (state_q == ST_DRAIN) && (cnt_q == '0) && !valid_q;

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed bench for mem_req_arbiter: vector table plus multi-cycle sequences.
module tb_mem_req_arbiter;
  import mem_req_arbiter_pkg::*;

  logic                               clk_i;
  logic                               rst_i;
  logic [NUM_REQ-1:0]                 req_valid_i;
  logic [NUM_REQ-1:0]                 req_ready_o;
  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0] req_addr_i;
  logic [NUM_REQ-1:0]                 req_we_i;
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] req_wdata_i;
  logic [NUM_REQ-1:0][BE_WIDTH-1:0]   req_be_i;
  logic [NUM_REQ-1:0][TID_WIDTH-1:0]  req_tid_i;
  logic                               mem_req_valid_o;
  logic                               mem_req_ready_i;
  logic [ADDR_WIDTH-1:0]              mem_req_addr_o;
  logic                               mem_req_we_o;
  logic [DATA_WIDTH-1:0]              mem_req_wdata_o;
  logic [BE_WIDTH-1:0]                mem_req_be_o;
  logic [ID_WIDTH-1:0]                mem_req_id_o;
  logic                               mem_rsp_valid_i;
  logic [ID_WIDTH-1:0]                mem_rsp_id_i;
  logic [DATA_WIDTH-1:0]              mem_rsp_data_i;
  logic [NUM_REQ-1:0]                 rsp_valid_o;
  logic [TID_WIDTH-1:0]               rsp_tid_o;
  logic [DATA_WIDTH-1:0]              rsp_data_o;
  logic                               drain_req_i;
  logic                               drain_done_o;
  logic                               err_o;

  localparam logic [63:0] A0 = 64'h0000_1000_0000_0040;
  localparam logic [63:0] A1 = 64'h0000_2000_0000_0080;
  localparam logic [63:0] D0 = 64'h1111_2222_3333_4444;
  localparam logic [63:0] D1 = 64'h5555_6666_7777_8888;
  localparam logic [63:0] RD = 64'hCAFE_F00D_1234_5678;

  int n_tests = 0;
  int n_fail  = 0;

  mem_req_arbiter dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .req_valid_i     (req_valid_i),
    .req_ready_o     (req_ready_o),
    .req_addr_i      (req_addr_i),
    .req_we_i        (req_we_i),
    .req_wdata_i     (req_wdata_i),
    .req_be_i        (req_be_i),
    .req_tid_i       (req_tid_i),
    .mem_req_valid_o (mem_req_valid_o),
    .mem_req_ready_i (mem_req_ready_i),
    .mem_req_addr_o  (mem_req_addr_o),
    .mem_req_we_o    (mem_req_we_o),
    .mem_req_wdata_o (mem_req_wdata_o),
    .mem_req_be_o    (mem_req_be_o),
    .mem_req_id_o    (mem_req_id_o),
    .mem_rsp_valid_i (mem_rsp_valid_i),
    .mem_rsp_id_i    (mem_rsp_id_i),
    .mem_rsp_data_i  (mem_rsp_data_i),
    .rsp_valid_o     (rsp_valid_o),
    .rsp_tid_o       (rsp_tid_o),
    .rsp_data_o      (rsp_data_o),
    .drain_req_i     (drain_req_i),
    .drain_done_o    (drain_done_o),
    .err_o           (err_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [1:0] valid;
    logic       mready;
    logic       rsp_v;
    logic [2:0] rsp_id;
    logic       drain;
    logic [1:0] exp_ready;
    logic       exp_mvalid;
    logic [2:0] exp_id;
    logic [1:0] exp_rsp;
    logic       exp_err;
    logic       exp_done;
  } vec_t;

  vec_t vecs [15];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic apply(input logic [1:0] v, input logic mr, input logic rv,
                       input logic [2:0] rid, input logic dr);
    req_valid_i     = v;
    mem_req_ready_i = mr;
    mem_rsp_valid_i = rv;
    mem_rsp_id_i    = rid;
    drain_req_i     = dr;
    #1;
  endtask

  task automatic nxt();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    apply(2'b00, 1'b0, 1'b0, 3'b000, 1'b0);
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
  endtask

  initial begin
    req_addr_i[0]  = A0;  req_addr_i[1]  = A1;
    req_we_i       = 2'b10;
    req_wdata_i[0] = D0;  req_wdata_i[1] = D1;
    req_be_i[0]    = 8'h0F; req_be_i[1]  = 8'hF0;
    req_tid_i[0]   = 2'b01; req_tid_i[1] = 2'b10;
    mem_rsp_data_i = RD;

    //           valid   mr    rv    rid     dr   | ready  mv    id      rsp    err   done
    vecs[0]  = '{2'b11, 1'b0, 1'b0, 3'b000, 1'b0, 2'b01, 1'b0, 3'b000, 2'b00, 1'b0, 1'b0};
    vecs[1]  = '{2'b11, 1'b1, 1'b0, 3'b000, 1'b0, 2'b00, 1'b1, 3'b001, 2'b00, 1'b0, 1'b0};
    vecs[2]  = '{2'b11, 1'b0, 1'b0, 3'b000, 1'b0, 2'b10, 1'b0, 3'b000, 2'b00, 1'b0, 1'b0};
    vecs[3]  = '{2'b11, 1'b1, 1'b0, 3'b000, 1'b0, 2'b00, 1'b1, 3'b110, 2'b00, 1'b0, 1'b0};
    vecs[4]  = '{2'b11, 1'b0, 1'b0, 3'b000, 1'b0, 2'b01, 1'b0, 3'b000, 2'b00, 1'b0, 1'b0};
    vecs[5]  = '{2'b11, 1'b1, 1'b0, 3'b000, 1'b0, 2'b00, 1'b1, 3'b001, 2'b00, 1'b0, 1'b0};
    vecs[6]  = '{2'b11, 1'b0, 1'b0, 3'b000, 1'b0, 2'b10, 1'b0, 3'b000, 2'b00, 1'b0, 1'b0};
    vecs[7]  = '{2'b11, 1'b1, 1'b0, 3'b000, 1'b0, 2'b00, 1'b1, 3'b110, 2'b00, 1'b0, 1'b0};
    vecs[8]  = '{2'b00, 1'b0, 1'b1, 3'b110, 1'b0, 2'b00, 1'b0, 3'b000, 2'b10, 1'b0, 1'b0};
    vecs[9]  = '{2'b00, 1'b0, 1'b1, 3'b001, 1'b0, 2'b00, 1'b0, 3'b000, 2'b01, 1'b0, 1'b0};
    vecs[10] = '{2'b00, 1'b0, 1'b1, 3'b001, 1'b0, 2'b00, 1'b0, 3'b000, 2'b01, 1'b0, 1'b0};
    vecs[11] = '{2'b00, 1'b0, 1'b1, 3'b001, 1'b0, 2'b00, 1'b0, 3'b000, 2'b01, 1'b0, 1'b0};
    vecs[12] = '{2'b00, 1'b0, 1'b0, 3'b000, 1'b0, 2'b00, 1'b0, 3'b000, 2'b00, 1'b1, 1'b0};
    vecs[13] = '{2'b00, 1'b0, 1'b1, 3'b110, 1'b0, 2'b00, 1'b0, 3'b000, 2'b10, 1'b1, 1'b0};
    vecs[14] = '{2'b00, 1'b0, 1'b1, 3'b101, 1'b0, 2'b00, 1'b0, 3'b000, 2'b10, 1'b1, 1'b0};

    // Reset state.
    do_reset();
    apply(2'b00, 1'b0, 1'b0, 3'b000, 1'b0);
    chk("rst_mvalid", 64'(mem_req_valid_o), 64'd0);
    chk("rst_addr",   mem_req_addr_o,       64'd0);
    chk("rst_id",     64'(mem_req_id_o),    64'd0);
    chk("rst_err",    64'(err_o),           64'd0);
    chk("rst_done",   64'(drain_done_o),    64'd0);
    chk("rst_ready",  64'(req_ready_o),     64'd0);

    // Round-robin alternation, response routing, error flag.
    for (int r = 0; r < 15; r++) begin
      apply(vecs[r].valid, vecs[r].mready, vecs[r].rsp_v, vecs[r].rsp_id, vecs[r].drain);
      chk($sformatf("v%0d_ready", r), 64'(req_ready_o), 64'(vecs[r].exp_ready));
      chk($sformatf("v%0d_mvalid", r), 64'(mem_req_valid_o), 64'(vecs[r].exp_mvalid));
      if (vecs[r].exp_mvalid) chk($sformatf("v%0d_id", r), 64'(mem_req_id_o), 64'(vecs[r].exp_id));
      chk($sformatf("v%0d_rsp", r), 64'(rsp_valid_o), 64'(vecs[r].exp_rsp));
      if (vecs[r].rsp_v) begin
        chk($sformatf("v%0d_rtid", r), 64'(rsp_tid_o), 64'(vecs[r].rsp_id[1:0]));
        chk($sformatf("v%0d_rdata", r), rsp_data_o, RD);
      end
      chk($sformatf("v%0d_err", r), 64'(err_o), 64'(vecs[r].exp_err));
      chk($sformatf("v%0d_done", r), 64'(drain_done_o), 64'(vecs[r].exp_done));
      nxt();
    end

    // Stall in HOLD: payload stable, no upstream accepts, regrant 2 cycles after release.
    do_reset();
    apply(2'b11, 1'b0, 1'b0, 3'b000, 1'b0);
    chk("st_ready0", 64'(req_ready_o), 64'b01);
    nxt();
    req_addr_i[0] = 64'hDEAD_BEEF_0000_0000;
    for (int k = 0; k < 5; k++) begin
      apply(2'b11, 1'b0, 1'b0, 3'b000, 1'b0);
      chk($sformatf("st%0d_mvalid", k), 64'(mem_req_valid_o), 64'd1);
      chk($sformatf("st%0d_addr", k), mem_req_addr_o, A0);
      chk($sformatf("st%0d_id", k), 64'(mem_req_id_o), 64'b001);
      chk($sformatf("st%0d_ready", k), 64'(req_ready_o), 64'd0);
      nxt();
    end
    chk("st_we",    64'(mem_req_we_o),   64'd0);
    chk("st_wdata", mem_req_wdata_o,     D0);
    chk("st_be",    64'(mem_req_be_o),   64'h0F);
    apply(2'b11, 1'b1, 1'b0, 3'b000, 1'b0);
    chk("st_rel_ready", 64'(req_ready_o), 64'd0);
    nxt();
    apply(2'b11, 1'b0, 1'b0, 3'b000, 1'b0);
    chk("st_gap_mvalid", 64'(mem_req_valid_o), 64'd0);
    chk("st_regrant", 64'(req_ready_o), 64'b10);
    nxt();
    chk("st_next_mvalid", 64'(mem_req_valid_o), 64'd1);
    chk("st_next_id",     64'(mem_req_id_o),    64'b110);
    chk("st_next_addr",   mem_req_addr_o,       A1);
    chk("st_next_we",     64'(mem_req_we_o),    64'd1);
    req_addr_i[0] = A0;

    // Outstanding cap on dcache, unblock by response, simultaneous accept+response.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      apply(2'b10, 1'b0, 1'b0, 3'b000, 1'b0);
      chk($sformatf("cap%0d_ready", k), 64'(req_ready_o), 64'b10);
      nxt();
      apply(2'b10, 1'b1, 1'b0, 3'b000, 1'b0);
      nxt();
    end
    apply(2'b11, 1'b1, 1'b0, 3'b000, 1'b0);
    chk("cap_full_ready", 64'(req_ready_o), 64'b01);
    nxt();
    apply(2'b11, 1'b1, 1'b1, 3'b100, 1'b0);
    chk("cap_rsp", 64'(rsp_valid_o), 64'b10);
    nxt();
    apply(2'b10, 1'b0, 1'b1, 3'b100, 1'b0);
    chk("cap_reaccept", 64'(req_ready_o), 64'b10);
    nxt();
    apply(2'b10, 1'b1, 1'b0, 3'b000, 1'b0);
    nxt();
    apply(2'b10, 1'b0, 1'b0, 3'b000, 1'b0);
    chk("cap_same_cyc_3", 64'(req_ready_o), 64'b10);
    nxt();
    apply(2'b10, 1'b1, 1'b0, 3'b000, 1'b0);
    nxt();
    apply(2'b10, 1'b0, 1'b0, 3'b000, 1'b0);
    chk("cap_same_cyc_4", 64'(req_ready_o), 64'b00);
    chk("cap_err", 64'(err_o), 64'd0);
    nxt();

    // Drain with two icache requests outstanding.
    do_reset();
    apply(2'b01, 1'b0, 1'b0, 3'b000, 1'b0);
    chk("dr_g0", 64'(req_ready_o), 64'b01);
    nxt();
    apply(2'b00, 1'b1, 1'b0, 3'b000, 1'b0);
    nxt();
    apply(2'b01, 1'b0, 1'b0, 3'b000, 1'b0);
    chk("dr_g1", 64'(req_ready_o), 64'b01);
    nxt();
    apply(2'b00, 1'b1, 1'b0, 3'b000, 1'b1);
    chk("dr_hold_done", 64'(drain_done_o), 64'd0);
    nxt();
    apply(2'b11, 1'b0, 1'b0, 3'b000, 1'b1);
    chk("dr_nogrant", 64'(req_ready_o), 64'd0);
    chk("dr_done_a", 64'(drain_done_o), 64'd0);
    nxt();
    apply(2'b00, 1'b0, 1'b1, 3'b001, 1'b1);
    chk("dr_done_b", 64'(drain_done_o), 64'd0);
    nxt();
    apply(2'b00, 1'b0, 1'b1, 3'b001, 1'b1);
    chk("dr_done_c", 64'(drain_done_o), 64'd0);
    nxt();
    apply(2'b11, 1'b0, 1'b0, 3'b000, 1'b1);
    chk("dr_done_rise", 64'(drain_done_o), 64'd1);
    chk("dr_nogrant2", 64'(req_ready_o), 64'd0);
    nxt();
    apply(2'b00, 1'b0, 1'b0, 3'b000, 1'b0);
    nxt();
    apply(2'b11, 1'b0, 1'b0, 3'b000, 1'b0);
    chk("dr_done_fall", 64'(drain_done_o), 64'd0);
    chk("dr_post_grant", 64'(req_ready_o), 64'b10);
    nxt();
    apply(2'b00, 1'b1, 1'b0, 3'b000, 1'b0);
    nxt();
    apply(2'b11, 1'b0, 1'b0, 3'b000, 1'b1);
    chk("dr_prio", 64'(req_ready_o), 64'd0);
    nxt();
    apply(2'b00, 1'b0, 1'b1, 3'b100, 1'b1);
    chk("dr_busy", 64'(drain_done_o), 64'd0);
    nxt();
    apply(2'b00, 1'b0, 1'b0, 3'b000, 1'b1);
    chk("dr_idle_done", 64'(drain_done_o), 64'd1);
    nxt();
    apply(2'b00, 1'b0, 1'b0, 3'b000, 1'b0);
    nxt();

    // Reset pulsed during HOLD.
    apply(2'b00, 1'b0, 1'b1, 3'b001, 1'b0);
    nxt();
    apply(2'b00, 1'b0, 1'b0, 3'b000, 1'b0);
    chk("rh_err_set", 64'(err_o), 64'd1);
    apply(2'b10, 1'b0, 1'b0, 3'b000, 1'b0);
    chk("rh_g_d", 64'(req_ready_o), 64'b10);
    nxt();
    apply(2'b00, 1'b1, 1'b0, 3'b000, 1'b0);
    nxt();
    apply(2'b01, 1'b0, 1'b0, 3'b000, 1'b0);
    chk("rh_g_i", 64'(req_ready_o), 64'b01);
    nxt();
    apply(2'b00, 1'b0, 1'b0, 3'b000, 1'b0);
    chk("rh_hold", 64'(mem_req_valid_o), 64'd1);
    #2;
    rst_i = 1'b1;
    #1;
    chk("rh_async_mvalid", 64'(mem_req_valid_o), 64'd0);
    chk("rh_async_err",    64'(err_o),           64'd0);
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    apply(2'b00, 1'b0, 1'b1, 3'b100, 1'b0);
    chk("rh_rsp_route", 64'(rsp_valid_o), 64'b10);
    nxt();
    apply(2'b11, 1'b0, 1'b0, 3'b000, 1'b0);
    chk("rh_cnt_cleared", 64'(err_o), 64'd1);
    chk("rh_tie_icache", 64'(req_ready_o), 64'b01);
    nxt();
    chk("rh_post_mvalid", 64'(mem_req_valid_o), 64'd1);
    chk("rh_post_id", 64'(mem_req_id_o), 64'b001);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
